// File: rtl/dircc_pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// dircc_pll_seq_pkg
// Shared types and constants for the PLL reset sequencer.
//   seq_state_e  : FSM state type with fixed encodings (software reads them
//                  through the status CSR, so the values must not move)
//   STATE_W      : width of the exported state field
//   RETRY_W      : width of the retry counter
//   LOSS_W       : width of the saturating lock-loss counter
//   sat_inc_loss : saturating increment for the lock-loss counter
// ---------------------------------------------------------------------------
package dircc_pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } seq_state_e;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] value);
    logic [LOSS_W-1:0] result;
    if (value == {LOSS_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + LOSS_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/dircc_sync2.sv
// ---------------------------------------------------------------------------
// dircc_sync2
// Generic two-flop single-bit synchronizer. Both stages clear to 0 on reset,
// so a level that was never seen is reported as low.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input level
//   q       : synchronized level (two clk edges of latency)
// ---------------------------------------------------------------------------
module dircc_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous level into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/dircc_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// dircc_pll_reset_sequencer
// Walks the system PLL through reset, lock acquisition and a lock-stability
// window, then releases a qualified system reset. A lock timeout retries the
// PLL reset a bounded number of times before parking in FAILED; lock loss in
// RUN or a software relock request restarts the whole sequence.
//   clk           : PLL reference clock, the only clock of the block
//   reset_n       : asynchronous active-low reset
//   pll_locked    : PLL locked pin, asynchronous to clk
//   relock_req    : one-cycle pulse forcing a full re-sequence
//   pll_rst       : PLL reset, active-high (registered)
//   sys_reset_n   : qualified system reset, active-low (registered)
//   failed        : every lock attempt timed out (registered)
//   state_o       : current FSM state encoding
//   retry_cnt     : timeouts taken in the current sequence
//   lock_loss_cnt : lock losses seen in RUN, saturating at 255
// ---------------------------------------------------------------------------
module dircc_pll_reset_sequencer
  import dircc_pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               failed,
  output logic [STATE_W-1:0] state_o,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  lock_loss_cnt
);

  // Terminal counts for the shared counter in each timed state.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ZERO   = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);

  logic              lock_s;
  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [RETRY_W-1:0] retry_r;
  logic [RETRY_W-1:0] retry_nxt_s;
  logic [LOSS_W-1:0] loss_r;
  logic [LOSS_W-1:0] loss_nxt_s;
  logic              pll_rst_r;
  logic              sys_reset_n_r;
  logic              failed_r;

  dircc_sync2 u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  // Next-state, counter and status update rules; relock_req overrides all.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_nxt_s = retry_r;
    loss_nxt_s  = loss_r;
    if (relock_req) begin
      // A software relock is not a lock loss, so loss_nxt_s is left alone.
      state_nxt_s = ST_RESET_PLL;
      cnt_nxt_s   = CNT_ZERO;
      retry_nxt_s = RETRY_ZERO;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt_s = ST_STABILIZE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == TIMEOUT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
            if (retry_r == RETRY_LIMIT) begin
              state_nxt_s = ST_FAILED;
            end else begin
              state_nxt_s = ST_RESET_PLL;
              retry_nxt_s = retry_r + RETRY_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_STABILIZE: begin
          // A drop even on the last qualifying cycle sends us back, and the
          // timeout window starts over from zero.
          if (!lock_s) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
            retry_nxt_s = RETRY_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt_s = ST_RESET_PLL;
            cnt_nxt_s   = CNT_ZERO;
            loss_nxt_s  = sat_inc_loss(loss_r);
          end else begin
            cnt_nxt_s = CNT_ZERO;
          end
        end
        ST_FAILED: begin
          // Parked with the PLL held in reset until software asks again.
          state_nxt_s = ST_FAILED;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_RESET_PLL;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_RESET_PLL;
      cnt_r         <= CNT_ZERO;
      retry_r       <= RETRY_ZERO;
      loss_r        <= {LOSS_W{1'b0}};
      pll_rst_r     <= 1'b1;
      sys_reset_n_r <= 1'b0;
      failed_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      retry_r       <= retry_nxt_s;
      loss_r        <= loss_nxt_s;
      pll_rst_r     <= (state_nxt_s == ST_RESET_PLL) || (state_nxt_s == ST_FAILED);
      sys_reset_n_r <= (state_nxt_s == ST_RUN);
      failed_r      <= (state_nxt_s == ST_FAILED);
    end
  end

  assign pll_rst       = pll_rst_r;
  assign sys_reset_n   = sys_reset_n_r;
  assign failed        = failed_r;
  assign state_o       = state_r;
  assign retry_cnt     = retry_r;
  assign lock_loss_cnt = loss_r;

endmodule

// File: tb/tb_dircc_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dircc_pll_reset_sequencer
// Scenario-driven bench. Each scenario works out, from the sequencing rules
// (pulse length, lock latency, stable window, timeout, retry limit), the clock
// cycle at which the visible outputs must next change and what they must
// change to, and queues that expectation. A separate monitor watches the
// output bundle every falling edge and pops one expectation per change.
// ---------------------------------------------------------------------------
module tb_dircc_pll_reset_sequencer;

  localparam int RP = 4;   // reset pulse cycles
  localparam int LS = 8;   // lock stable cycles
  localparam int LT = 32;  // lock timeout cycles
  localparam int MR = 2;   // max retries

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       failed;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [17:0] dut_vec;

  dircc_pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (LT),
    .MAX_RETRIES         (MR),
    .CNT_W               (6)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .failed        (failed),
    .state_o       (state_o),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  assign dut_vec = {state_o, pll_rst, sys_reset_n, failed, retry_cnt, lock_loss_cnt};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [17:0] vec;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  int          m_loss = 0;
  logic [17:0] last_vec;

  // Output bundle implied by a state: PLL in reset in RESET_PLL/FAILED,
  // system out of reset only in RUN, failed only in FAILED.
  function automatic logic [17:0] mkvec(input int st, input int r, input int l);
    return {3'(st), (st == 0 || st == 4), (st == 3), (st == 4), 4'(r), 8'(l)};
  endfunction

  function automatic int sat(input int l);
    return (l >= 255) ? 255 : l + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic push(input int t, input int st, input int r, input int l);
    ev_t e;
    m_loss = l;
    e.cyc = t;
    e.vec = mkvec(st, r, l);
    if (e.vec != last_vec) begin
      exp_q.push_back(e);
      last_vec = e.vec;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_vec(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: one queued expectation per observed output change.
  initial begin : monitor
    logic [17:0] prev;
    ev_t         e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en && dut_vec !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change", dut_vec, cyc);
        end else begin
          e = exp_q.pop_front();
          if (dut_vec !== e.vec || cyc != e.cyc) begin
            bad++;
            $display("FAIL output_event: got %h at cycle %0d, required %h at cycle %0d",
                     dut_vec, cyc, e.vec, e.cyc);
          end
        end
      end
      prev = dut_vec;
    end
  end

  // From RUN: drop lock, expect a full re-sequence, re-lock `down` cycles later.
  task automatic loss_cycle(input int down, input int hold);
    int c, w, t, s;
    c = cyc;
    pll_locked = 1'b0;
    push(c + 3, 0, 0, sat(m_loss));
    w = c + 3 + RP;
    push(w, 1, 0, m_loss);
    t = c + down;
    wait_to(t);
    pll_locked = 1'b1;
    s = max2(t + 3, w + 1);
    push(s, 2, 0, m_loss);
    push(s + LS, 3, 0, m_loss);
    wait_to(s + LS + hold);
  endtask

  // From RUN: relock request (optionally coinciding with lock loss), then a
  // one-cycle lock glitch seen by the FSM at STABILIZE cycle goff+3.
  task automatic relock_run(input bit with_loss, input int goff);
    int c, r, w, t, s, g;
    c = cyc;
    if (with_loss) begin
      pll_locked = 1'b0;
      r = c + 2;
    end else begin
      r = c;
    end
    wait_to(r);
    relock_req = 1'b1;
    push(r + 1, 0, 0, m_loss);
    wait_to(r + 1);
    relock_req = 1'b0;
    w = r + 1 + RP;
    push(w, 1, 0, m_loss);
    if (with_loss) begin
      t = r + 1 + int'($urandom_range(1, 10));
      wait_to(t);
      pll_locked = 1'b1;
      s = max2(t + 3, w + 1);
    end else begin
      s = w + 1;
    end
    push(s, 2, 0, m_loss);
    g = s + goff;
    wait_to(g);
    pll_locked = 1'b0;
    push(g + 3, 1, 0, m_loss);
    push(g + 4, 2, 0, m_loss);
    push(g + 4 + LS, 3, 0, m_loss);
    wait_to(g + 1);
    pll_locked = 1'b1;
    wait_to(g + 4 + LS + 2);
  endtask

  // From RUN: lose lock for good; every attempt times out until FAILED.
  task automatic timeout_fail();
    int c, w;
    c = cyc;
    pll_locked = 1'b0;
    push(c + 3, 0, 0, sat(m_loss));
    w = c + 3 + RP;
    push(w, 1, 0, m_loss);
    for (int r = 0; r <= MR; r++) begin
      if (r < MR) begin
        push(w + LT, 0, r + 1, m_loss);
        w = w + LT + RP;
        push(w, 1, r + 1, m_loss);
      end else begin
        push(w + LT, 4, r, m_loss);
      end
    end
    wait_to(w + LT + 5);
  endtask

  // From FAILED: relock request, new pulse, lock returns, back to RUN.
  task automatic relock_failed();
    int c, w, t, s;
    c = cyc;
    relock_req = 1'b1;
    push(c + 1, 0, 0, m_loss);
    wait_to(c + 1);
    relock_req = 1'b0;
    w = c + 1 + RP;
    push(w, 1, 0, m_loss);
    t = c + 1 + int'($urandom_range(1, 10));
    wait_to(t);
    pll_locked = 1'b1;
    s = max2(t + 3, w + 1);
    push(s, 2, 0, m_loss);
    push(s + LS, 3, 0, m_loss);
    wait_to(s + LS + 3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c, w, s, t;
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #3 reset_n = 1'b0;
    @(negedge clk);
    check_vec("reset_values", dut_vec, mkvec(0, 0, 0));
    last_vec = mkvec(0, 0, 0);
    m_loss   = 0;
    mon_en   = 1'b1;
    @(negedge clk);

    // Nominal bring-up: lock rises 10 cycles after reset release.
    c = cyc;
    reset_n = 1'b1;
    w = c + RP;
    push(w, 1, 0, 0);
    t = c + 10;
    wait_to(t);
    pll_locked = 1'b1;
    s = max2(t + 3, w + 1);
    push(s, 2, 0, 0);
    push(s + LS, 3, 0, 0);
    wait_to(s + LS + 3);

    loss_cycle(int'($urandom_range(1, 20)), 2);
    relock_run(1'b1, int'($urandom_range(0, LS - 3)));
    relock_run(1'b0, LS - 3);
    timeout_fail();
    relock_failed();

    for (int i = 0; i < 258; i++) begin
      loss_cycle(int'($urandom_range(1, 20)), int'($urandom_range(1, 6)));
    end

    // Asynchronous reset in the middle of STABILIZE.
    c = cyc;
    relock_req = 1'b1;
    push(c + 1, 0, 0, m_loss);
    wait_to(c + 1);
    relock_req = 1'b0;
    w = c + 1 + RP;
    push(w, 1, 0, m_loss);
    s = w + 1;
    push(s, 2, 0, m_loss);
    wait_to(s + int'($urandom_range(1, 6)));
    #2 reset_n = 1'b0;
    #1 check_vec("async_reset", dut_vec, mkvec(0, 0, 0));
    push(cyc + 1, 0, 0, 0);
    wait_to(cyc + 4);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d unconsumed expectations, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
